// File: rtl/systolic_pkg.sv
// systolic_pkg
//   Shared definitions for the systolicFilter sequencer: default sizes,
//   the controller state encoding and a constant ceil(log2) helper used
//   to size address and counter fields.
package systolic_pkg;

   localparam int unsigned TAPS_DEFAULT    = 16;
   localparam int unsigned DATA_W_DEFAULT  = 18;
   localparam int unsigned COEF_W_DEFAULT  = 18;
   localparam int unsigned LATENCY_DEFAULT = 18;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DRAIN = 3'd1,
      ST_LOAD  = 3'd2,
      ST_FLUSH = 3'd3,
      ST_RUN   = 3'd4
   } ctrl_state_e;

   // Bits needed to hold 0..value-1; never returns less than 1 so that
   // degenerate sizes still give a legal vector.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned width;
      width = 1;
      while ((64'd1 << width) < 64'(value)) width++;
      return width;
   endfunction

endpackage

// File: rtl/systolic_filter_ctrl_if.sv
// systolic_filter_ctrl_if
//   Bundles every non-clock/reset signal of systolic_filter_ctrl:
//     source side : Data_i, DataNd_i, DataReady_o
//     host config : CoefStart_i, CoefData_i, CoefNd_i, CoefReady_o
//     filter side : FiltData_o, FiltDataNd_o, FiltCoef_o, FiltCoefAddr_o,
//                   FiltCoefWe_o, FiltData_i, FiltDataValid_i
//     downstream  : Data_o, DataValid_o
//     status      : Busy_o, ErrOverrun_o
//   Suffixes are from the controller's point of view. The controller
//   connects through modport slave; the surrounding system through master.
interface systolic_filter_ctrl_if #(
   parameter int unsigned DATA_W = 18,
   parameter int unsigned COEF_W = 18,
   parameter int unsigned ADDR_W = 4
);
   logic              CoefStart_i;
   logic [COEF_W-1:0] CoefData_i;
   logic              CoefNd_i;
   logic              CoefReady_o;
   logic [DATA_W-1:0] Data_i;
   logic              DataNd_i;
   logic              DataReady_o;
   logic [DATA_W-1:0] FiltData_o;
   logic              FiltDataNd_o;
   logic [COEF_W-1:0] FiltCoef_o;
   logic [ADDR_W-1:0] FiltCoefAddr_o;
   logic              FiltCoefWe_o;
   logic [DATA_W-1:0] FiltData_i;
   logic              FiltDataValid_i;
   logic [DATA_W-1:0] Data_o;
   logic              DataValid_o;
   logic              Busy_o;
   logic              ErrOverrun_o;

   modport slave (
      input  CoefStart_i, CoefData_i, CoefNd_i, Data_i, DataNd_i,
             FiltData_i, FiltDataValid_i,
      output CoefReady_o, DataReady_o, FiltData_o, FiltDataNd_o, FiltCoef_o,
             FiltCoefAddr_o, FiltCoefWe_o, Data_o, DataValid_o, Busy_o,
             ErrOverrun_o
   );

   modport master (
      output CoefStart_i, CoefData_i, CoefNd_i, Data_i, DataNd_i,
             FiltData_i, FiltDataValid_i,
      input  CoefReady_o, DataReady_o, FiltData_o, FiltDataNd_o, FiltCoef_o,
             FiltCoefAddr_o, FiltCoefWe_o, Data_o, DataValid_o, Busy_o,
             ErrOverrun_o
   );

endinterface

// File: rtl/systolic_ctrl_cnt.sv
// systolic_ctrl_cnt
//   Loadable down-counter with terminal flag, shared by the DRAIN,
//   LOAD-address and FLUSH phases of the sequencer.
//   Ports:
//     Clk_i, Rst_i  clock, synchronous active-high reset (count -> 0)
//     load          load count with load_value (wins over dec)
//     load_value    value to load
//     dec           decrement by one, saturating at zero
//     count         current count
//     terminal      count == 0
module systolic_ctrl_cnt #(
   parameter int unsigned WIDTH = 5
) (
   input  logic             Clk_i,
   input  logic             Rst_i,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dec,
   output logic [WIDTH-1:0] count,
   output logic             terminal
);

   always_ff @(posedge Clk_i) begin
      if (Rst_i) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign terminal = (count == '0);

endmodule

// File: rtl/systolic_filter_ctrl.sv
// systolic_filter_ctrl
//   Sequencer in front of the shared systolicFilter datapath. Owns the
//   filter coefficient write port and sample strobe; on a reload request it
//   stalls the source, drains in-flight results, loads a full coefficient
//   set, zero-flushes the delay line and masks the flush results.
//   Ports:
//     Clk_i  clock
//     Rst_i  synchronous active-high reset
//     bus    systolic_filter_ctrl_if.slave (source, host config, filter and
//            downstream signals; see the interface file)
//   Build option:
//     SYSTOLIC_CTRL_FLUSH_EN  when defined, LOAD is followed by a TAPS-cycle
//     zero flush and the first TAPS filter results are discarded; when
//     undefined, LOAD goes straight to RUN with no masking.
module systolic_filter_ctrl
   import systolic_pkg::*;
#(
   parameter int unsigned TAPS    = TAPS_DEFAULT,
   parameter int unsigned DATA_W  = DATA_W_DEFAULT,
   parameter int unsigned COEF_W  = COEF_W_DEFAULT,
   parameter int unsigned LATENCY = LATENCY_DEFAULT
) (
   input logic                  Clk_i,
   input logic                  Rst_i,
   systolic_filter_ctrl_if.slave bus
);

   localparam int unsigned ADDR_W = clog2(TAPS);
   localparam int unsigned CNT_W  = clog2((LATENCY > TAPS) ? LATENCY : TAPS);
   localparam logic [CNT_W-1:0] TAPS_LAST  = CNT_W'(TAPS - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(LATENCY - 1);

   ctrl_state_e       state;
   logic              cnt_load;
   logic              cnt_dec;
   logic [CNT_W-1:0]  cnt_value;
   logic [CNT_W-1:0]  cnt;
   logic              cnt_zero;

   logic              data_ready;
   logic              coef_ready;
   logic [DATA_W-1:0] filt_data;
   logic              filt_nd;
   logic [COEF_W-1:0] filt_coef;
   logic [ADDR_W-1:0] coef_addr;
   logic              coef_we;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              err_overrun;

`ifdef SYSTOLIC_CTRL_FLUSH_EN
   localparam int unsigned DISC_W = clog2(TAPS + 1);
   logic [DISC_W-1:0] discard;
`endif

   // Handshake readies decode the current state so a transfer completes in
   // the cycle it is offered.
   assign data_ready = (state == ST_RUN);
   assign coef_ready = (state == ST_LOAD);

   // One counter serves all timed phases: DRAIN counts LATENCY-1..0, LOAD
   // counts TAPS-1..0 per accepted word (address = TAPS-1-count), FLUSH
   // counts TAPS-1..0 per zero sample.
   always_comb begin
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      cnt_value = '0;
      case (state)
         ST_IDLE: begin
            if (bus.CoefStart_i) begin
               cnt_load  = 1'b1;
               cnt_value = TAPS_LAST;
            end
         end
         ST_RUN: begin
            if (bus.CoefStart_i) begin
               cnt_load  = 1'b1;
               cnt_value = DRAIN_LAST;
            end
         end
         ST_DRAIN: begin
            if (cnt_zero) begin
               cnt_load  = 1'b1;
               cnt_value = TAPS_LAST;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_LOAD: begin
            if (bus.CoefNd_i) begin
               if (cnt_zero) begin
                  cnt_load  = 1'b1;
                  cnt_value = TAPS_LAST;
               end else begin
                  cnt_dec = 1'b1;
               end
            end
         end
         ST_FLUSH: cnt_dec = 1'b1;
         default: ;
      endcase
   end

   systolic_ctrl_cnt #(
      .WIDTH(CNT_W)
   ) u_cnt (
      .Clk_i      (Clk_i),
      .Rst_i      (Rst_i),
      .load       (cnt_load),
      .load_value (cnt_value),
      .dec        (cnt_dec),
      .count      (cnt),
      .terminal   (cnt_zero)
   );

   always_ff @(posedge Clk_i) begin
      if (Rst_i) begin
         state       <= ST_IDLE;
         filt_data   <= '0;
         filt_nd     <= 1'b0;
         filt_coef   <= '0;
         coef_addr   <= '0;
         coef_we     <= 1'b0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         err_overrun <= 1'b0;
`ifdef SYSTOLIC_CTRL_FLUSH_EN
         discard     <= '0;
`endif
      end else begin
         filt_nd  <= 1'b0;
         coef_we  <= 1'b0;
         data_out <= bus.FiltData_i;
`ifdef SYSTOLIC_CTRL_FLUSH_EN
         data_valid <= bus.FiltDataValid_i && (discard == '0);
         if (bus.FiltDataValid_i && (discard != '0)) begin
            discard <= discard - DISC_W'(1);
         end
`else
         data_valid <= bus.FiltDataValid_i;
`endif
         if (bus.DataNd_i && !data_ready) begin
            err_overrun <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (bus.CoefStart_i) state <= ST_LOAD;
            end
            ST_RUN: begin
               if (bus.DataNd_i) begin
                  filt_data <= bus.Data_i;
                  filt_nd   <= 1'b1;
               end
               if (bus.CoefStart_i) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (cnt_zero) state <= ST_LOAD;
            end
            ST_LOAD: begin
               if (bus.CoefNd_i) begin
                  filt_coef <= bus.CoefData_i;
                  coef_we   <= 1'b1;
                  coef_addr <= ADDR_W'(TAPS_LAST - cnt);
                  if (cnt_zero) begin
`ifdef SYSTOLIC_CTRL_FLUSH_EN
                     // First zero is issued on the entry edge so the TAPS
                     // strobes coincide exactly with the FLUSH cycles.
                     state     <= ST_FLUSH;
                     filt_nd   <= 1'b1;
                     filt_data <= '0;
                     discard   <= DISC_W'(TAPS);
`else
                     state <= ST_RUN;
`endif
                  end
               end
            end
            ST_FLUSH: begin
               if (cnt_zero) begin
                  state <= ST_RUN;
               end else begin
                  filt_nd   <= 1'b1;
                  filt_data <= '0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.DataReady_o    = data_ready;
   assign bus.CoefReady_o    = coef_ready;
   assign bus.FiltData_o     = filt_data;
   assign bus.FiltDataNd_o   = filt_nd;
   assign bus.FiltCoef_o     = filt_coef;
   assign bus.FiltCoefAddr_o = coef_addr;
   assign bus.FiltCoefWe_o   = coef_we;
   assign bus.Data_o         = data_out;
   assign bus.DataValid_o    = data_valid;
   assign bus.ErrOverrun_o   = err_overrun;
   // Busy is held low while reset is asserted so every output reads 0 then;
   // afterwards it is high in every state except RUN.
   assign bus.Busy_o         = !Rst_i && (state != ST_RUN);

endmodule

// File: tb/tb_systolic_filter_ctrl.sv
// tb_systolic_filter_ctrl
//   Self-checking bench for systolic_filter_ctrl with a LATENCY-cycle
//   identity filter stand-in and a scoreboard of expected downstream
//   results. Expectations follow SYSTOLIC_CTRL_FLUSH_EN when defined.
module tb_systolic_filter_ctrl;
   import systolic_pkg::*;

   localparam int unsigned TAPS   = 16;
   localparam int unsigned DATA_W = 18;
   localparam int unsigned COEF_W = 18;
   localparam int unsigned LAT    = 18;
   localparam int unsigned ADDR_W = clog2(TAPS);
   localparam int          NVEC   = 40;

   logic Clk_i = 1'b0;
   logic Rst_i = 1'b1;
   always #5 Clk_i = ~Clk_i;

   systolic_filter_ctrl_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ADDR_W(ADDR_W)) bus ();

   systolic_filter_ctrl #(
      .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .LATENCY(LAT)
   ) dut (
      .Clk_i (Clk_i),
      .Rst_i (Rst_i),
      .bus   (bus.slave)
   );

   // Filter stand-in: result equals the strobed sample, LAT cycles later.
   logic [LAT-1:0]    vpipe;
   logic [DATA_W-1:0] dpipe [LAT];
   always @(posedge Clk_i) begin
      if (Rst_i) vpipe <= '0;
      else       vpipe <= {vpipe[LAT-2:0], bus.FiltDataNd_o};
      dpipe[0] <= bus.FiltData_o;
      for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
   end
   assign bus.FiltDataValid_i = vpipe[LAT-1];
   assign bus.FiltData_i      = dpipe[LAT-1];

   int n_checks = 0;
   int n_fail   = 0;
   logic [DATA_W-1:0] sb [$];
   bit src_en  = 1'b0;
   bit exp_run = 1'b0;
   int src_idx = 0;
   int we_cnt  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] chirp(input int i);
      real ph;
      ph = 0.002 * real'(i) * real'(i);
      return DATA_W'(int'(65536.0 * $sin(ph)));
   endfunction

   // One clock: optional streaming source, then settle past the edge.
   task automatic step();
      if (src_en) begin
         bus.Data_i   = chirp(src_idx);
         bus.DataNd_i = 1'b1;
         if (exp_run) sb.push_back(bus.Data_i);
         src_idx++;
      end else begin
         bus.DataNd_i = 1'b0;
      end
      @(posedge Clk_i);
      #1;
   endtask

   // Coefficient write monitor: words are sent as 1,2,3,... per load.
   initial forever begin
      @(posedge Clk_i);
      #1;
      if (bus.FiltCoefWe_o) begin
         check($sformatf("coef_addr[%0d]", we_cnt), 64'(bus.FiltCoefAddr_o), 64'(we_cnt % TAPS));
         check($sformatf("coef_data[%0d]", we_cnt), 64'(bus.FiltCoef_o), 64'(we_cnt + 1));
         we_cnt++;
      end
   end

   // Downstream result monitor against the scoreboard.
   initial forever begin
      @(posedge Clk_i);
      #1;
      if (bus.DataValid_o) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", 64'(bus.DataValid_o), 64'd0);
         end else begin
            logic [DATA_W-1:0] e;
            e = sb.pop_front();
            check("data_out", 64'(bus.Data_o), 64'(e));
         end
      end
   end

   task automatic load_coefs(input bit from_run, input int gap, input bit dup, input int n_words);
      int n;
      we_cnt = 0;
      bus.CoefStart_i = 1'b1;
      step();
      bus.CoefStart_i = 1'b0;
      exp_run = 1'b0;
      if (from_run) check("ready_drop", 64'(bus.DataReady_o), 64'd0);
      n = 0;
      while (!bus.CoefReady_o && n < 200) begin
         n++;
         step();
      end
      check("drain_cycles", 64'(n), from_run ? 64'(LAT) : 64'd0);
      for (int w = 1; w <= n_words; w++) begin
         check($sformatf("coef_ready[%0d]", w), 64'(bus.CoefReady_o), 64'd1);
         bus.CoefData_i = COEF_W'(w);
         bus.CoefNd_i   = 1'b1;
         if (dup && w == 5) bus.CoefStart_i = 1'b1;
         step();
         bus.CoefNd_i    = 1'b0;
         bus.CoefStart_i = 1'b0;
         if (w < n_words) repeat (gap) step();
      end
      if (n_words < int'(TAPS)) return;
`ifdef SYSTOLIC_CTRL_FLUSH_EN
      for (int i = 0; i < int'(TAPS); i++) begin
         check($sformatf("flush_zero[%0d]", i), {63'd0, bus.FiltDataNd_o} | (64'(bus.FiltData_o) << 1), 64'd1);
         check($sformatf("flush_busy[%0d]", i), {62'd0, bus.Busy_o, bus.DataReady_o}, 64'b10);
         step();
      end
`endif
      check("run_entry", {61'd0, bus.Busy_o, bus.DataReady_o, bus.FiltDataNd_o}, 64'b010);
      exp_run = 1'b1;
      #2;
      check("coef_writes", 64'(we_cnt), 64'(TAPS));
      check("inflight_drained", 64'(sb.size()), 64'd0);
   endtask

   typedef struct {
      logic              nd;
      logic [DATA_W-1:0] data;
      logic              exp_nd;
      logic [DATA_W-1:0] exp_data;
   } vec_t;
   vec_t vecs [NVEC];

   initial begin
      for (int i = 0; i < NVEC; i++) begin
         vecs[i].nd       = (i % 7) != 6;
         vecs[i].data     = chirp(1000 + i);
         vecs[i].exp_nd   = vecs[i].nd;
         vecs[i].exp_data = vecs[i].data;
      end
      bus.CoefStart_i = 1'b0;
      bus.CoefData_i  = '0;
      bus.CoefNd_i    = 1'b0;
      bus.Data_i      = '0;
      bus.DataNd_i    = 1'b0;

      // Reset values
      Rst_i = 1'b1;
      repeat (3) step();
      check("reset_flags", {56'd0, bus.CoefReady_o, bus.DataReady_o, bus.FiltDataNd_o,
            bus.FiltCoefWe_o, bus.DataValid_o, bus.Busy_o, bus.ErrOverrun_o, 1'b0}, 64'd0);
      check("reset_filt_bus", {24'd0, bus.FiltData_o, bus.FiltCoef_o, bus.FiltCoefAddr_o}, 64'd0);
      check("reset_data_o", 64'(bus.Data_o), 64'd0);
      Rst_i = 1'b0;
      step();
      check("idle_state", {61'd0, bus.Busy_o, bus.DataReady_o, bus.CoefReady_o}, 64'b100);

      // First load from IDLE
      load_coefs(1'b0, 0, 1'b0, TAPS);
      check("no_overrun_yet", 64'(bus.ErrOverrun_o), 64'd0);

      // RUN: table-driven chirp, strobe follows the source by one cycle
      for (int i = 0; i < NVEC; i++) begin
         bus.Data_i   = vecs[i].data;
         bus.DataNd_i = vecs[i].nd;
         if (vecs[i].nd) sb.push_back(vecs[i].data);
         @(posedge Clk_i);
         #1;
         check($sformatf("run_nd[%0d]", i), 64'(bus.FiltDataNd_o), 64'(vecs[i].exp_nd));
         if (vecs[i].exp_nd)
            check($sformatf("run_data[%0d]", i), 64'(bus.FiltData_o), 64'(vecs[i].exp_data));
      end
      bus.DataNd_i = 1'b0;
      repeat (LAT + 4) step();
      check("run_drained", 64'(sb.size()), 64'd0);
      check("run_no_overrun", 64'(bus.ErrOverrun_o), 64'd0);

      // Reload from RUN with source held busy, stretched LOAD, stray start
      src_en = 1'b1;
      load_coefs(1'b1, 1, 1'b1, TAPS);
      check("overrun_set", 64'(bus.ErrOverrun_o), 64'd1);
      repeat (30) step();
      src_en = 1'b0;
      repeat (LAT + 4) step();
      check("reload_drained", 64'(sb.size()), 64'd0);
      check("overrun_sticky", 64'(bus.ErrOverrun_o), 64'd1);

      // Reset clears overrun; then reset mid-LOAD
      Rst_i = 1'b1;
      exp_run = 1'b0;
      step();
      Rst_i = 1'b0;
      step();
      check("overrun_cleared", 64'(bus.ErrOverrun_o), 64'd0);
      load_coefs(1'b0, 0, 1'b0, 7);
      Rst_i = 1'b1;
      step();
      check("abort_addr", 64'(bus.FiltCoefAddr_o), 64'd0);
      check("abort_ready", {62'd0, bus.DataReady_o, bus.CoefReady_o}, 64'd0);
      Rst_i = 1'b0;
      step();
      check("abort_idle", {61'd0, bus.Busy_o, bus.DataReady_o, bus.CoefReady_o}, 64'b100);
      check("abort_writes", 64'(we_cnt), 64'd7);
      load_coefs(1'b0, 0, 1'b0, TAPS);
      src_en = 1'b1;
      repeat (10) step();
      src_en = 1'b0;
      repeat (LAT + 4) step();
      check("final_drained", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
